pmips_hazard_ctrl: RTL and testbench
====================================

Name: pmips_hazard_ctrl

Overview:
Pipeline sequencing controller for the 16-bit pipelined PMIPS core. Each cycle it generates PC stall, IF/ID stall, ID/EX bubble, flush and redirect controls. It owns the branch-history table of 2-bit saturating counters that supplies the IF-stage taken prediction, and it counts mispredictions for debug. It sits beside the datapath. It takes inputs from IF, ID and EX, and its outputs drive the PC register, the pipeline-register enables and clears, and the PCSrc redirect mux.

Parameters:
IDX_W, 3, BHT index width; table has 2**IDX_W entries
CTR_INIT, 2'b01, reset value of every BHT counter (weakly not-taken)
BOOT_CYCLES, 2, cycles after reset release during which the pipeline is held and flushed

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_pc  in  16  IF-stage PC (byte address, 16-bit instructions); BHT index = if_pc[IDX_W:1]
id_rs  in  3  ID-stage source register rs
id_rt  in  3  ID-stage source register rt
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  EX instruction is a load
ex_rd  in  3  EX load destination register
ex_br_valid  in  1  EX holds a resolved conditional branch
ex_br_taken  in  1  actual branch outcome
ex_br_pred  in  1  prediction carried down with that branch
ex_br_pc  in  16  PC of the EX branch; index = ex_br_pc[IDX_W:1]
predict_taken  out  1  IF prediction = MSB of BHT[if index]
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
idex_bubble  out  1  load NOP into ID/EX
flush  out  1  clear IF/ID and ID/EX
redirect  out  1  select the EX-computed correct PC
ctrl_state  out  3  FSM state: BOOT=0, RUN=1, LDSTALL=2, FLUSH=3
mispredict_cnt  out  16  saturating misprediction count

Behaviour:
- Reset (async, reset=0) sets: FSM=BOOT, boot counter=0, all BHT entries=CTR_INIT, mispredict_cnt=0. While in reset: pc_stall=1, flush=1, all other control outputs 0, predict_taken=CTR_INIT[1].
- Hazard and flush outputs are combinational from the current state and inputs. Effect is same-cycle; no added latency.
- mispredict = ex_br_valid & (ex_br_taken != ex_br_pred).
- loaduse = ex_memread & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- BOOT state:
  - Outputs: pc_stall=1, flush=1, redirect=0. Branch and hazard inputs are ignored; no BHT update.
  - After BOOT_CYCLES clocks in BOOT, next state is RUN.
  - BOOT_CYCLES=0 means the FSM enters RUN on the first edge.
- RUN state:
  - If mispredict: flush=1, redirect=1, pc_stall=0. Next state FLUSH. A load-use hazard in the same cycle is ignored, because the flush kills the ID instruction.
  - Else if loaduse: pc_stall=1, ifid_stall=1, idex_bubble=1. Next state LDSTALL.
  - Else: all controls 0; stay in RUN.
- LDSTALL state (one cycle):
  - loaduse is masked.
  - A mispredict is still honoured, using the RUN mispredict outputs; next state FLUSH.
  - Otherwise next state RUN.
- FLUSH state (one cycle):
  - loaduse is masked.
  - A mispredict in EX is impossible here (EX holds a bubble); if asserted, it is honoured exactly as in RUN.
  - Otherwise next state RUN.
- BHT update, on a clock edge with ex_br_valid=1 in any non-BOOT state: BHT[ex index] +1 if taken, -1 if not taken, saturating at 3 and 0.
- Same-index read and update in one cycle: predict_taken uses the pre-update value (no bypass).
- mispredict_cnt increments on each edge where mispredict=1 outside BOOT, and holds at 16'hFFFF.
- Reset asserted mid-operation aborts any stall or flush immediately and restarts the BOOT sequence.

Test Plan:
- Reset release, with BOOT_CYCLES=2 and default params:
  - Required: pc_stall=1 and flush=1 for exactly 2 cycles, ctrl_state=0, then ctrl_state=1.
  - Required: predict_taken=0 for every if_pc.
- Load-use: ex_memread=1, ex_rd=3, id_rs=3, id_uses_rs=1, held for 2 cycles.
  - Required: stall/bubble asserted in cycle 1 only, ctrl_state=2 in cycle 2, back to 1.
  - Negative cases: ex_rd=0 gives no stall; id_uses_rs=0 gives no stall.
- Training: two taken branches at ex_br_pc=16'h0006.
  - Required: BHT[3] goes 1→2→3; predict_taken=1 for if_pc=16'h0006 from the cycle after the first update; if_pc=16'h0016 (same index) also predicts 1.
  - Three not-taken updates at the same PC drive the counter to 0 and predict_taken=0.
- Mispredict with simultaneous load-use (ex_br_pred=0, ex_br_taken=1, loaduse true):
  - Required: flush=1, redirect=1, pc_stall=0, ctrl_state→3 then 1, mispredict_cnt=1.
- Saturation: force 65536 mispredicts.
  - Required: mispredict_cnt stays 16'hFFFF.
- Mid-operation reset: assert reset=0 asynchronously during LDSTALL.
  - Required: ctrl_state=0 immediately (no clock edge); BHT back to 2'b01; mispredict_cnt=0.

Source files
------------

// File: rtl/pmips_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pmips_hazard_ctrl_if
// Bundle between the PMIPS datapath and the pipeline sequencing controller.
//   master : datapath side. Drives the IF/ID/EX status and reads the controls.
//   slave  : controller side. Reads the status and drives predict_taken,
//            the stall/bubble/flush/redirect controls, ctrl_state and
//            mispredict_cnt.
// -----------------------------------------------------------------------------
interface pmips_hazard_ctrl_if;
    // IF stage
    logic [15:0] if_pc;
    // ID stage
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    // EX stage
    logic        ex_memread;
    logic [2:0]  ex_rd;
    logic        ex_br_valid;
    logic        ex_br_taken;
    logic        ex_br_pred;
    logic [15:0] ex_br_pc;
    // controls back to the datapath
    logic        predict_taken;
    logic        pc_stall;
    logic        ifid_stall;
    logic        idex_bubble;
    logic        flush;
    logic        redirect;
    logic [2:0]  ctrl_state;
    logic [15:0] mispredict_cnt;

    modport master (
        output if_pc, id_rs, id_rt, id_uses_rs, id_uses_rt,
               ex_memread, ex_rd, ex_br_valid, ex_br_taken, ex_br_pred, ex_br_pc,
        input  predict_taken, pc_stall, ifid_stall, idex_bubble, flush, redirect,
               ctrl_state, mispredict_cnt
    );

    modport slave (
        input  if_pc, id_rs, id_rt, id_uses_rs, id_uses_rt,
               ex_memread, ex_rd, ex_br_valid, ex_br_taken, ex_br_pred, ex_br_pc,
        output predict_taken, pc_stall, ifid_stall, idex_bubble, flush, redirect,
               ctrl_state, mispredict_cnt
    );
endinterface

// File: rtl/pmips_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pmips_hazard_ctrl
// Pipeline sequencing controller for the 16-bit PMIPS core. Produces the
// same-cycle PC stall, IF/ID stall, ID/EX bubble, flush and redirect controls,
// owns the branch-history table (2-bit saturating counters) that supplies the
// IF-stage prediction, and counts mispredictions for debug.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low reset
//   hz    : pmips_hazard_ctrl_if.slave (IF/ID/EX status in, controls out)
//
// FSM states:
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   BOOT    0  | post-reset hold: PC stalled, pipeline flushed, inputs ignored
//   RUN     1  | normal issue; reacts to mispredict / load-use
//   LDSTALL 2  | one-cycle load-use bubble in flight; load-use masked
//   FLUSH   3  | one-cycle after redirect; EX holds a bubble, load-use masked
// -----------------------------------------------------------------------------
module pmips_hazard_ctrl #(
    parameter int         IDX_W       = 3,
    parameter logic [1:0] CTR_INIT    = 2'b01,
    parameter int         BOOT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    pmips_hazard_ctrl_if.slave    hz
);

    localparam int N_ENT = 1 << IDX_W;
    localparam int BC_W  = (BOOT_CYCLES > 2) ? $clog2(BOOT_CYCLES) : 1;
    // 0 and 1 both leave BOOT on the first edge after reset release.
    localparam logic [BC_W-1:0] BOOT_LAST = (BOOT_CYCLES > 1) ? BC_W'(BOOT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_LDSTALL = 3'd2,
        ST_FLUSH   = 3'd3
    } state_e;

    state_e            state_q, state_d;
    logic [BC_W-1:0]   boot_cnt_q, boot_cnt_d;
    logic [1:0]        bht_q [N_ENT];
    logic [1:0]        bht_d [N_ENT];
    logic [15:0]       mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic              mispredict;
    logic              loaduse;
    logic              boot_done;

    // Instruction addresses are halfword aligned, so bit 0 never indexes.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{hz.if_pc[15:IDX_W+1], hz.if_pc[0],
                              hz.ex_br_pc[15:IDX_W+1], hz.ex_br_pc[0]};

    assign if_idx     = hz.if_pc[IDX_W:1];
    assign ex_idx     = hz.ex_br_pc[IDX_W:1];
    assign mispredict = hz.ex_br_valid & (hz.ex_br_taken != hz.ex_br_pred);
    assign loaduse    = hz.ex_memread & (hz.ex_rd != 3'd0) &
                        ((hz.id_uses_rs & (hz.id_rs == hz.ex_rd)) |
                         (hz.id_uses_rt & (hz.id_rt == hz.ex_rd)));
    assign boot_done  = (boot_cnt_q == BOOT_LAST);

    // ------------------------------------------------------------------
    // State register and datapath flops
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            mis_cnt_q  <= '0;
            for (int i = 0; i < N_ENT; i++) begin
                bht_q[i] <= CTR_INIT;
            end
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
            for (int i = 0; i < N_ENT; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        unique case (state_q)
            ST_BOOT: begin
                if (boot_done) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (mispredict) begin
                    state_d = ST_FLUSH;
                end else if (loaduse) begin
                    state_d = ST_LDSTALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LDSTALL, ST_FLUSH: begin
                state_d = mispredict ? ST_FLUSH : ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // BHT training and misprediction count; both frozen during BOOT.
    always_comb begin
        for (int i = 0; i < N_ENT; i++) begin
            bht_d[i] = bht_q[i];
        end
        mis_cnt_d = mis_cnt_q;
        if (state_q != ST_BOOT) begin
            if (hz.ex_br_valid) begin
                if (hz.ex_br_taken) begin
                    if (bht_q[ex_idx] != 2'b11) begin
                        bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
                    end
                end else begin
                    if (bht_q[ex_idx] != 2'b00) begin
                        bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
                    end
                end
            end
            if (mispredict && (mis_cnt_q != 16'hFFFF)) begin
                mis_cnt_d = mis_cnt_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic (same-cycle from state and inputs)
    // ------------------------------------------------------------------
    logic pc_stall_c, ifid_stall_c, idex_bubble_c, flush_c, redirect_c;

    always_comb begin
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        idex_bubble_c = 1'b0;
        flush_c       = 1'b0;
        redirect_c    = 1'b0;
        if (state_q == ST_BOOT) begin
            pc_stall_c = 1'b1;
            flush_c    = 1'b1;
        end else if (mispredict) begin
            // The flush kills the ID instruction, so a coincident load-use
            // hazard needs no stall.
            flush_c    = 1'b1;
            redirect_c = 1'b1;
        end else if ((state_q == ST_RUN) && loaduse) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_bubble_c = 1'b1;
        end
    end

    // Prediction reads the registered counter: no bypass of a same-cycle update.
    assign hz.predict_taken  = bht_q[if_idx][1];
    assign hz.pc_stall       = pc_stall_c;
    assign hz.ifid_stall     = ifid_stall_c;
    assign hz.idex_bubble    = idex_bubble_c;
    assign hz.flush          = flush_c;
    assign hz.redirect       = redirect_c;
    assign hz.ctrl_state     = state_q;
    assign hz.mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_pmips_hazard_ctrl.sv
module tb_pmips_hazard_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pmips_hazard_ctrl_if hz ();

    pmips_hazard_ctrl #(
        .IDX_W(3),
        .CTR_INIT(2'b01),
        .BOOT_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hz(hz)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // {pc_stall, ifid_stall, idex_bubble, flush, redirect}
    logic [4:0] ctl;
    assign ctl = {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.flush, hz.redirect};

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        hz.if_pc       = 16'h0000;
        hz.id_rs       = 3'd0;
        hz.id_rt       = 3'd0;
        hz.id_uses_rs  = 1'b0;
        hz.id_uses_rt  = 1'b0;
        hz.ex_memread  = 1'b0;
        hz.ex_rd       = 3'd0;
        hz.ex_br_valid = 1'b0;
        hz.ex_br_taken = 1'b0;
        hz.ex_br_pred  = 1'b0;
        hz.ex_br_pc    = 16'h0000;
    endtask

    task automatic set_loaduse_rs3;
        hz.ex_memread = 1'b1;
        hz.ex_rd      = 3'd3;
        hz.id_rs      = 3'd3;
        hz.id_uses_rs = 1'b1;
    endtask

    // Release from reset and walk the two BOOT cycles into RUN.
    task automatic boot_sequence(input string tag);
        reset = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 5'b10010 || hz.ctrl_state !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_boot1: ctl=%b state=%0d, required ctl=10010 state=0", tag, ctl, hz.ctrl_state);
        end
        step();
        n_checks++;
        if (ctl !== 5'b10010 || hz.ctrl_state !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_boot2: ctl=%b state=%0d, required ctl=10010 state=0", tag, ctl, hz.ctrl_state);
        end
        hz.ex_br_valid = 1'b0;
        step();
        n_checks++;
        if (ctl !== 5'b00000 || hz.ctrl_state !== 3'd1) begin
            n_fail++;
            $display("FAIL %s_run: ctl=%b state=%0d, required ctl=00000 state=1", tag, ctl, hz.ctrl_state);
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b0;
        // A mispredicting branch during reset/BOOT must neither count nor train.
        hz.ex_br_valid = 1'b1;
        hz.ex_br_taken = 1'b1;
        hz.ex_br_pred  = 1'b0;
        hz.ex_br_pc    = 16'h0002;
        #3;
        n_checks++;
        if (ctl !== 5'b10010 || hz.ctrl_state !== 3'd0 || hz.predict_taken !== 1'b0 ||
            hz.mispredict_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL in_reset: ctl=%b state=%0d pred=%b cnt=%h, required 10010 0 0 0000",
                     ctl, hz.ctrl_state, hz.predict_taken, hz.mispredict_cnt);
        end
        step();
        boot_sequence("reset");
        n_checks++;
        if (hz.mispredict_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL boot_no_count: cnt=%h, required 0000", hz.mispredict_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            hz.if_pc = 16'(i * 2);
            #1;
            n_checks++;
            if (hz.predict_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL init_predict: if_pc=%h pred=%b, required 0", hz.if_pc, hz.predict_taken);
            end
        end
    endtask

    task automatic test_load_use;
        idle_inputs();
        set_loaduse_rs3();
        #1;
        n_checks++;
        if (ctl !== 5'b11100 || hz.ctrl_state !== 3'd1) begin
            n_fail++;
            $display("FAIL loaduse_c1: ctl=%b state=%0d, required 11100 1", ctl, hz.ctrl_state);
        end
        step();
        n_checks++;
        if (ctl !== 5'b00000 || hz.ctrl_state !== 3'd2) begin
            n_fail++;
            $display("FAIL loaduse_c2: ctl=%b state=%0d, required 00000 2", ctl, hz.ctrl_state);
        end
        idle_inputs();
        step();
        n_checks++;
        if (ctl !== 5'b00000 || hz.ctrl_state !== 3'd1) begin
            n_fail++;
            $display("FAIL loaduse_back: ctl=%b state=%0d, required 00000 1", ctl, hz.ctrl_state);
        end
        // r0 destination never stalls even though id_rs==ex_rd
        hz.ex_memread = 1'b1; hz.ex_rd = 3'd0; hz.id_rs = 3'd0; hz.id_uses_rs = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++;
            $display("FAIL loaduse_rd0: ctl=%b, required 00000", ctl);
        end
        step();
        n_checks++;
        if (hz.ctrl_state !== 3'd1) begin
            n_fail++;
            $display("FAIL loaduse_rd0_state: state=%0d, required 1", hz.ctrl_state);
        end
        set_loaduse_rs3();
        hz.id_uses_rs = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++;
            $display("FAIL loaduse_norsuse: ctl=%b, required 00000", ctl);
        end
        // rt path
        idle_inputs();
        hz.ex_memread = 1'b1; hz.ex_rd = 3'd5; hz.id_rt = 3'd5; hz.id_uses_rt = 1'b1;
        hz.id_rs = 3'd5;  // rs matches but is not used
        #1;
        n_checks++;
        if (ctl !== 5'b11100) begin
            n_fail++;
            $display("FAIL loaduse_rt: ctl=%b, required 11100", ctl);
        end
        step();
        n_checks++;
        if (ctl !== 5'b00000 || hz.ctrl_state !== 3'd2) begin
            n_fail++;
            $display("FAIL loaduse_rt_masked: ctl=%b state=%0d, required 00000 2", ctl, hz.ctrl_state);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_training;
        idle_inputs();
        hz.if_pc = 16'h0006;
        hz.ex_br_pc = 16'h0006;
        hz.ex_br_valid = 1'b1; hz.ex_br_taken = 1'b1; hz.ex_br_pred = 1'b1;
        #1;
        n_checks++;
        if (hz.predict_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL train_no_bypass: pred=%b, required 0", hz.predict_taken);
        end
        step();
        n_checks++;
        if (hz.predict_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL train_ctr2: pred=%b, required 1", hz.predict_taken);
        end
        step();
        hz.ex_br_valid = 1'b0;
        #1;
        n_checks++;
        if (hz.predict_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL train_ctr3: pred=%b, required 1", hz.predict_taken);
        end
        hz.if_pc = 16'h0016;
        #1;
        n_checks++;
        if (hz.predict_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL train_alias: pred=%b, required 1", hz.predict_taken);
        end
        hz.if_pc = 16'h0008;
        #1;
        n_checks++;
        if (hz.predict_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL train_other_idx: pred=%b, required 0", hz.predict_taken);
        end
        // Counter 3 -> 2 -> 1 -> 0 -> 0 (floor) -> 1 -> 2 ; expected MSB per step
        hz.if_pc = 16'h0006;
        hz.ex_br_valid = 1'b1; hz.ex_br_taken = 1'b0; hz.ex_br_pred = 1'b0;
        for (int k = 0; k < 6; k++) begin
            logic exp_p;
            if (k == 4) begin
                hz.ex_br_taken = 1'b1; hz.ex_br_pred = 1'b1;
            end
            exp_p = (k == 0 || k == 5) ? 1'b1 : 1'b0;
            step();
            n_checks++;
            if (hz.predict_taken !== exp_p) begin
                n_fail++;
                $display("FAIL train_step%0d: pred=%b, required %b", k, hz.predict_taken, exp_p);
            end
        end
        idle_inputs();
        #1;
        n_checks++;
        if (hz.ctrl_state !== 3'd1 || hz.mispredict_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL train_state: state=%0d cnt=%h, required 1 0000", hz.ctrl_state, hz.mispredict_cnt);
        end
    endtask

    task automatic test_mispredict;
        idle_inputs();
        set_loaduse_rs3();
        hz.ex_br_pc = 16'h000A;
        hz.ex_br_valid = 1'b1; hz.ex_br_taken = 1'b1; hz.ex_br_pred = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 5'b00011 || hz.ctrl_state !== 3'd1) begin
            n_fail++;
            $display("FAIL mis_run: ctl=%b state=%0d, required 00011 1", ctl, hz.ctrl_state);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (ctl !== 5'b00000 || hz.ctrl_state !== 3'd3 || hz.mispredict_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL mis_flush: ctl=%b state=%0d cnt=%h, required 00000 3 0001",
                     ctl, hz.ctrl_state, hz.mispredict_cnt);
        end
        step();
        n_checks++;
        if (hz.ctrl_state !== 3'd1 || hz.mispredict_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL mis_back: state=%0d cnt=%h, required 1 0001", hz.ctrl_state, hz.mispredict_cnt);
        end
        // Mispredict arriving while in LDSTALL
        set_loaduse_rs3();
        step();
        hz.ex_br_pc = 16'h000A;
        hz.ex_br_valid = 1'b1; hz.ex_br_taken = 1'b0; hz.ex_br_pred = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 5'b00011 || hz.ctrl_state !== 3'd2) begin
            n_fail++;
            $display("FAIL mis_ldstall: ctl=%b state=%0d, required 00011 2", ctl, hz.ctrl_state);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (hz.ctrl_state !== 3'd3 || hz.mispredict_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL mis_ldstall_flush: state=%0d cnt=%h, required 3 0002", hz.ctrl_state, hz.mispredict_cnt);
        end
        step();
    endtask

    task automatic test_saturation;
        idle_inputs();
        hz.ex_br_pc = 16'h000C;
        hz.ex_br_valid = 1'b1; hz.ex_br_taken = 1'b1; hz.ex_br_pred = 1'b0;
        // count starts at 2; 65532 edges reach FFFE
        for (int k = 0; k < 65532; k++) begin
            @(posedge clock);
        end
        #1;
        n_checks++;
        if (hz.mispredict_cnt !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_fffe: cnt=%h, required fffe", hz.mispredict_cnt);
        end
        step();
        n_checks++;
        if (hz.mispredict_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_ffff: cnt=%h, required ffff", hz.mispredict_cnt);
        end
        repeat (4) step();
        n_checks++;
        if (hz.mispredict_cnt !== 16'hFFFF || hz.ctrl_state !== 3'd3 || ctl !== 5'b00011) begin
            n_fail++;
            $display("FAIL sat_hold: cnt=%h state=%0d ctl=%b, required ffff 3 00011",
                     hz.mispredict_cnt, hz.ctrl_state, ctl);
        end
        idle_inputs();
        step();
        n_checks++;
        if (hz.ctrl_state !== 3'd1 || hz.mispredict_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_back: state=%0d cnt=%h, required 1 ffff", hz.ctrl_state, hz.mispredict_cnt);
        end
    endtask

    task automatic test_mid_reset;
        idle_inputs();
        set_loaduse_rs3();
        step();
        n_checks++;
        if (hz.ctrl_state !== 3'd2) begin
            n_fail++;
            $display("FAIL midrst_pre: state=%0d, required 2", hz.ctrl_state);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (hz.ctrl_state !== 3'd0 || ctl !== 5'b10010 || hz.mispredict_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_async: state=%0d ctl=%b cnt=%h, required 0 10010 0000",
                     hz.ctrl_state, ctl, hz.mispredict_cnt);
        end
        idle_inputs();
        hz.if_pc = 16'h0006;  // counter was 2
        #1;
        n_checks++;
        if (hz.predict_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_bht3: pred=%b, required 0", hz.predict_taken);
        end
        hz.if_pc = 16'h000C;  // counter was saturated at 3
        #1;
        n_checks++;
        if (hz.predict_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_bht6: pred=%b, required 0", hz.predict_taken);
        end
        step();
        boot_sequence("midrst");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_training();
        test_mispredict();
        test_saturation();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
